sample_mul_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one 2-stage pipelined 6x11 multiplier among N_REQ requesters.

---
 rtl/sample_mul_pkg.sv | 18 +
 rtl/sample_mul_tagged_pipe.sv | 61 ++++++
 rtl/sample_mul_rr_sched.sv | 92 +++++++++
 tb/tb_sample_mul_rr_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_mul_pkg.sv
// Shared widths and helpers for the round-robin scheduled 6x11 multiplier.
package sample_mul_pkg;

    localparam int A_W     = 6;
    localparam int B_W     = 11;
    localparam int P_W     = 11;
    localparam int MUL_LAT = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_mul_tagged_pipe.sv
// Two-stage (a,b)->p multiplier pipe with a clock enable and a valid/id tag shadow
// that travels alongside the data with identical depth.
module sample_mul_tagged_pipe
    import sample_mul_pkg::*;
#(
    parameter int ID_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_i,
    input  logic                  in_valid_i,
    input  logic [ID_W-1:0]       in_id_i,
    input  logic [A_W-1:0]        a_i,
    input  logic signed [B_W-1:0] b_i,
    output logic                  out_valid_o,
    output logic [ID_W-1:0]       out_id_o,
    output logic [P_W-1:0]        p_o,
    output logic                  busy_o
);

    logic [MUL_LAT-1:0]           tv_q;
    logic [MUL_LAT-1:0][ID_W-1:0] tid_q;
    logic [A_W-1:0]               a1_q;
    logic signed [B_W-1:0]        b1_q;
    logic [P_W-1:0]               p2_q;
    logic signed [A_W+B_W:0]      prod_full;
    logic [P_W-1:0]               p2_d;

    // a is unsigned: a zero MSB keeps it non-negative in the signed multiply.
    assign prod_full = $signed({1'b0, a1_q}) * b1_q;
    assign p2_d      = prod_full[P_W-1:0];

    // NOTE: the operand and product registers are reset as well, so res_p reads 0
    // after reset instead of leaking a stale product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv_q  <= '0;
            tid_q <= '0;
            a1_q  <= '0;
            b1_q  <= '0;
            p2_q  <= '0;
        end else if (ce_i) begin
            tv_q <= {tv_q[MUL_LAT-2:0], in_valid_i};
            for (int s = 1; s < MUL_LAT; s++) begin
                tid_q[s] <= tid_q[s-1];
            end
            if (in_valid_i) begin
                tid_q[0] <= in_id_i;
                a1_q     <= a_i;
                b1_q     <= b_i;
            end
            p2_q <= p2_d;
        end
    end

    assign out_valid_o = tv_q[MUL_LAT-1];
    assign out_id_o    = tid_q[MUL_LAT-1];
    assign p_o         = p2_q;
    assign busy_o      = |tv_q;

endmodule

// File: rtl/sample_mul_rr_sched.sv
// Round-robin scheduler sharing one pipelined 6x11 multiplier among N_REQ requesters;
// results return on one channel tagged with the requester index.
module sample_mul_rr_sched
    import sample_mul_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_p,
    output logic                   busy
);

    localparam int SUM_W = ID_W + 1;

    logic                 ce;
    logic                 issue;
    logic                 gnt_any;
    logic [ID_W-1:0]      gnt_id;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      ptr_d;
    logic [2*N_REQ-1:0]   rot_full;
    logic [N_REQ-1:0]     rot;
    logic [SUM_W-1:0]     sum;

    assign ce = ~res_valid | res_ready;

    // Rotate the requests so index 0 is the pointer, pick the lowest set bit,
    // then map the offset back to a requester index modulo N_REQ.
    assign rot_full = {req_valid, req_valid} >> ptr_q;
    assign rot      = rot_full[N_REQ-1:0];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_any = 1'b1;
                sum     = {1'b0, ptr_q} + SUM_W'(k);
            end
        end
        if (sum >= SUM_W'(N_REQ)) begin
            sum = sum - SUM_W'(N_REQ);
        end
        gnt_id = sum[ID_W-1:0];
    end

    assign issue     = ce & gnt_any;
    assign req_ready = (issue && reset_n) ? (N_REQ'(1) << gnt_id) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    sample_mul_tagged_pipe #(
        .ID_W (ID_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (reset_n),
        .ce_i        (ce),
        .in_valid_i  (issue),
        .in_id_i     (gnt_id),
        .a_i         (req_a[gnt_id*A_W +: A_W]),
        .b_i         (req_b[gnt_id*B_W +: B_W]),
        .out_valid_o (res_valid),
        .out_id_o    (res_id),
        .p_o         (res_p),
        .busy_o      (busy)
    );

endmodule

// File: tb/tb_sample_mul_rr_sched.sv
// Self-checking bench for sample_mul_rr_sched: directed scenarios plus random traffic
// checked every cycle against a behavioural scheduler/multiplier model.
module tb_sample_mul_rr_sched;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*6-1:0]    req_a = '0;
    logic [N*11-1:0]   req_b = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [1:0]        res_id;
    logic [10:0]       res_p;
    logic              busy;

    sample_mul_rr_sched #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: an op occupies "issued" then "result" slots; result is offered until taken.
    typedef struct { bit v; int id; int p; } op_t;
    op_t st1, st2;
    int  m_ptr;
    int  m_gnt;
    int  m_new_p;
    bit  m_ce;

    int gnt_log[$];
    int gnt_cyc_log[$];
    int res_id_log[$];
    int res_p_log[$];
    int res_cyc_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int p11(input int v);
        return v & 'h7FF;
    endfunction

    function automatic int exp_prod(input int a, input int b_raw);
        int bs;
        bs = (b_raw >= 1024) ? b_raw - 2048 : b_raw;
        return p11(a * bs);
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input int a, input int b);
        req_valid[i]        = v;
        req_a[i*6 +: 6]     = 6'(a);
        req_b[i*11 +: 11]   = 11'(b);
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        gnt_cyc_log.delete();
        res_id_log.delete();
        res_p_log.delete();
        res_cyc_log.delete();
    endtask

    task automatic m_reset();
        st1 = '{v: 1'b0, id: 0, p: 0};
        st2 = '{v: 1'b0, id: 0, p: 0};
        m_ptr = 0;
    endtask

    task automatic eval();
        logic [N-1:0] exp_ready;
        logic [N-1:0] hs;
        m_ce  = !st2.v || res_ready;
        m_gnt = m_ce ? pick(req_valid, m_ptr) : -1;
        exp_ready = '0;
        m_new_p = 0;
        if (m_gnt >= 0) begin
            exp_ready[m_gnt] = 1'b1;
            m_new_p = exp_prod(int'(req_a[m_gnt*6 +: 6]), int'(req_b[m_gnt*11 +: 11]));
        end
        check("req_ready", req_ready, exp_ready);
        check("res_valid", res_valid, st2.v);
        if (st2.v) begin
            check("res_id", res_id, st2.id);
            check("res_p", res_p, st2.p);
        end
        check("busy", busy, st1.v | st2.v);
        hs = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                gnt_log.push_back(i);
                gnt_cyc_log.push_back(cyc);
            end
        end
        if (res_valid && res_ready) begin
            res_id_log.push_back(int'(res_id));
            res_p_log.push_back(int'(res_p));
            res_cyc_log.push_back(cyc);
        end
    endtask

    task automatic update();
        if (m_ce) begin
            st2 = st1;
            if (m_gnt >= 0) begin
                st1 = '{v: 1'b1, id: m_gnt, p: m_new_p};
                m_ptr = (m_gnt + 1) % N;
            end else begin
                st1.v = 1'b0;
            end
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        #1;
        eval();
        @(posedge clk);
        update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, res_valid, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_p"}, res_p, 0);
        check({tag, "_rst_id"}, res_id, 0);
        check({tag, "_rst_ptr"}, dut.ptr_q, 0);
        check({tag, "_rst_ready"}, req_ready, 0);
        m_reset();
        #2;
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_reset();
        #2;
        check("por_valid", res_valid, 0);
        check("por_busy", busy, 0);
        check("por_ready", req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: reset with both stages occupied
        clear_logs();
        set_req(0, 1'b1, 7, 9);
        res_ready = 1'b0;
        step();
        step();
        #1;
        check("t1_full", {res_valid, busy}, 2'b11);
        do_reset("t1");
        idle(3);
        check("t1_dropped", res_id_log.size(), 0);

        // 2: single op latency and value
        clear_logs();
        set_req(2, 1'b1, 5, -3);
        res_ready = 1'b1;
        step();
        idle(4);
        check("t2_nres", res_id_log.size(), 1);
        if (res_id_log.size() == 1) begin
            check("t2_id", res_id_log[0], 2);
            check("t2_p", res_p_log[0], p11(-15));
            check("t2_lat", res_cyc_log[0] - gnt_cyc_log[0], 2);
        end

        // 3: product wrap corners, back to back
        clear_logs();
        set_req(0, 1'b1, 63, 1023);
        step();
        set_req(0, 1'b1, 63, -1024);
        step();
        set_req(0, 1'b1, 0, -1);
        step();
        idle(4);
        check("t3_nres", res_p_log.size(), 3);
        if (res_p_log.size() == 3) begin
            check("t3_p0", res_p_log[0], 961);
            check("t3_p1", res_p_log[1], p11(-1024));
            check("t3_p2", res_p_log[2], 0);
        end

        // 4: fairness with all requesters valid
        req_valid = '0;
        do_reset("t4");
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < N; r++) set_req(r, 1'b1, 10 * r + i, 100 - 37 * r - i);
            step();
        end
        idle(4);
        check("t4_ngnt", gnt_log.size(), 8);
        check("t4_nres", res_id_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < gnt_log.size()) check("t4_gnt", gnt_log[i], i % N);
            if (i < res_id_log.size()) check("t4_res", res_id_log[i], i % N);
        end

        // 5: backpressure mid-stream
        clear_logs();
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 3 + r, -200 + 77 * r);
        for (int i = 0; i < 3; i++) step();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t5_stall_gnt", gnt_log.size(), 3);
        check("t5_stall_res", res_id_log.size(), 1);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t5_resume_gnt", gnt_log.size(), 7);
        idle(4);
        check("t5_nres", res_id_log.size(), 7);
        for (int i = 0; i < 7 && i < res_id_log.size(); i++) begin
            check("t5_order", res_id_log[i], (i < 3) ? i : (i - 3 + 3) % N);
        end

        // 6: sparse requests then reset with two ops in flight
        do_reset("t6a");
        clear_logs();
        set_req(3, 1'b1, 11, 13);
        step();
        check("t6_ptr0", dut.ptr_q, 0);
        req_valid = '0;
        set_req(1, 1'b1, 17, -19);
        step();
        check("t6_ptr2", dut.ptr_q, 2);
        check("t6_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check("t6_g0", gnt_log[0], 3);
            check("t6_g1", gnt_log[1], 1);
        end
        req_valid = '0;
        do_reset("t6b");
        idle(4);
        check("t6_dropped", res_id_log.size(), 0);

        // Random traffic against the model
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) begin
                set_req(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                        int'($urandom_range(0, 2047)));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle(4);
        check("rnd_count", res_id_log.size(), gnt_log.size());
        for (int i = 0; i < res_id_log.size() && i < gnt_log.size(); i++) begin
            check("rnd_order", res_id_log[i], gnt_log[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
